exe_muldiv: RTL

EXE_MULDIV -- requirements
Module: exe_muldiv

---
 rtl/riscv_pkg.sv | 31 +++
 rtl/muldiv_div_core.sv | 77 +++++++
 rtl/exe_muldiv.sv | 122 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the execute-stage M-extension unit: funct3 opcodes,
// FSM states and divider sizing.
package riscv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned DIV_ITERS = 32;

   // Divide and remainder ops share funct3[2]; unsigned variants have funct3[0] set.
   function automatic logic op_is_signed_div(input logic [2:0] op);
      return op[2] & ~op[0];
   endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Radix-2 restoring divider on operand magnitudes; fixed 32 iterations, with
// sign correction and divide-by-zero handling applied to the final step.
module muldiv_div_core
   import riscv_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   input  logic            signed_i,
   output logic            done_o,
   output logic [XLEN-1:0] quotient_o,
   output logic [XLEN-1:0] remainder_o
);

   logic [5:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] dq_q, dq_d, rem_q, rem_d, dvs_q, dvs_d;
   logic            neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
   logic [XLEN:0]   partial;
   logic [XLEN+1:0] diff;
   logic            q_bit;
   logic [XLEN-1:0] rem_step, dq_step;
   logic            unused_diff;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q     <= '0;
         dq_q      <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         dq_q      <= dq_d;
         rem_q     <= rem_d;
         dvs_q     <= dvs_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end

   // dq_q shifts dividend bits out of the top while quotient bits enter the bottom.
   always_comb begin
      partial   = {rem_q, dq_q[XLEN-1]};
      diff      = {1'b0, partial} - {2'b00, dvs_q};
      q_bit     = ~diff[XLEN+1];
      rem_step  = q_bit ? diff[XLEN-1:0] : partial[XLEN-1:0];
      dq_step   = {dq_q[XLEN-2:0], q_bit};
      cnt_d     = cnt_q;
      dq_d      = dq_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      if (start_i) begin
         cnt_d     = 6'(DIV_ITERS);
         rem_d     = '0;
         dq_d      = (signed_i && dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
         dvs_d     = (signed_i && divisor_i[XLEN-1]) ? -divisor_i : divisor_i;
         // A zero divisor leaves the all-ones quotient un-negated.
         neg_quo_d = signed_i && (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]) && (divisor_i != '0);
         neg_rem_d = signed_i && dividend_i[XLEN-1];
      end else if (cnt_q != 6'd0) begin
         cnt_d = cnt_q - 6'd1;
         rem_d = rem_step;
         dq_d  = dq_step;
      end
   end

   assign unused_diff = diff[XLEN];
   assign done_o      = (cnt_q == 6'd1);
   assign quotient_o  = neg_quo_q ? -dq_step : dq_step;
   assign remainder_o = neg_rem_q ? -rem_step : rem_step;

endmodule

// File: rtl/exe_muldiv.sv
// Execute-stage RISC-V M-extension unit: 2-cycle multiply, 33-cycle iterative
// divide, stalling the upstream stages while busy.
module exe_muldiv
   import riscv_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] ra_i,
   input  logic [XLEN-1:0] rb_i,
   input  logic [4:0]      rd_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            valid_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_o
);

   // Handshake: start_i is taken only in IDLE (flush_i wins); stall_o holds the
   // upstream stage until the DONE cycle, where valid_o pulses once with the result.
   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [XLEN-1:0]   ra_q, ra_d, rb_q, rb_d, result_q, result_d;
   logic [4:0]        rd_lat_q, rd_lat_d, rd_q, rd_d;
   logic              accept, load_res, div_done;
   logic [XLEN-1:0]   div_quo, div_rem, res_sel;
   logic signed [XLEN:0]     mul_a, mul_b;
   logic signed [2*XLEN+1:0] mul_p;
   logic              unused_mul_hi;

   assign accept = (state_q == ST_IDLE) && start_i && !flush_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = op_i[2] ? ST_DIV : ST_MUL;
         ST_MUL:  state_d = ST_DONE;
         ST_DIV:  if (div_done) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (flush_i) state_d = ST_IDLE;
   end

   always_comb begin
      stall_o  = 1'b0;
      valid_o  = 1'b0;
      load_res = 1'b0;
      case (state_q)
         ST_IDLE: stall_o = accept;
         ST_MUL:  begin stall_o = 1'b1; load_res = !flush_i; end
         ST_DIV:  begin stall_o = 1'b1; load_res = div_done && !flush_i; end
         ST_DONE: valid_o = 1'b1;
         default: ;
      endcase
      stall_o = stall_o & rst_ni;
   end

   // One 33x33 signed multiply covers all four variants via the extension bit.
   always_comb begin
      mul_a = {((op_q == OP_MULH) || (op_q == OP_MULHSU)) & ra_q[XLEN-1], ra_q};
      mul_b = {(op_q == OP_MULH) & rb_q[XLEN-1], rb_q};
      mul_p = mul_a * mul_b;
      case (op_q)
         OP_MUL:                        res_sel = mul_p[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  res_sel = mul_p[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:               res_sel = div_quo;
         default:                       res_sel = div_rem;
      endcase
   end

   assign unused_mul_hi = ^mul_p[2*XLEN+1:2*XLEN];

   always_comb begin
      op_d     = accept ? op_e'(op_i) : op_q;
      ra_d     = accept ? ra_i : ra_q;
      rb_d     = accept ? rb_i : rb_q;
      rd_lat_d = accept ? rd_i : rd_lat_q;
      result_d = load_res ? res_sel : result_q;
      rd_d     = load_res ? rd_lat_q : rd_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op_q     <= OP_MUL;
         ra_q     <= '0;
         rb_q     <= '0;
         rd_lat_q <= '0;
         result_q <= '0;
         rd_q     <= '0;
      end else begin
         op_q     <= op_d;
         ra_q     <= ra_d;
         rb_q     <= rb_d;
         rd_lat_q <= rd_lat_d;
         result_q <= result_d;
         rd_q     <= rd_d;
      end
   end

   muldiv_div_core u_div (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .start_i     (accept && op_i[2]),
      .dividend_i  (ra_i),
      .divisor_i   (rb_i),
      .signed_i    (op_is_signed_div(op_i)),
      .done_o      (div_done),
      .quotient_o  (div_quo),
      .remainder_o (div_rem)
   );

   assign result_o = result_q;
   assign rd_o     = rd_q;

endmodule
